// File: rtl/i2s_rx_deserializer_if.sv
// Bundle of the raw I2S receive lines and the decoded stereo sample outputs.
// The deserializer uses the slave view; the codec side/bench uses master.
interface i2s_rx_deserializer_if #(
   parameter int SAMPLE_WIDTH = 24
);
   logic                    i2s_bclk;
   logic                    i2s_lr;
   logic                    i2s_sdata;
   logic [SAMPLE_WIDTH-1:0] line_in_l;
   logic [SAMPLE_WIDTH-1:0] line_in_r;
   logic                    new_sample;
   logic                    frame_error;

   modport master (
      output i2s_bclk, i2s_lr, i2s_sdata,
      input  line_in_l, line_in_r, new_sample, frame_error
   );

   modport slave (
      input  i2s_bclk, i2s_lr, i2s_sdata,
      output line_in_l, line_in_r, new_sample, frame_error
   );
endinterface

// File: rtl/i2s_rx_deserializer.sv
// I2S ADC-stream deserializer: oversamples bclk/lr/sdata in the clk domain and
// emits a left/right sample pair with a one-cycle new_sample strobe per frame.
module i2s_rx_deserializer #(
   parameter int SAMPLE_WIDTH = 24,
   parameter int SYNC_STAGES  = 2
) (
   input logic                  clk,
   input logic                  reset,
   i2s_rx_deserializer_if.slave bus
);
   localparam int CNT_W = $clog2(SAMPLE_WIDTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SAMPLE_WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLE_WIDTH - 1);

   logic [SYNC_STAGES-1:0]  bclk_sync_reg;
   logic [SYNC_STAGES-1:0]  lr_sync_reg;
   logic [SYNC_STAGES-1:0]  sdata_sync_reg;
   logic                    bclk_s;
   logic                    lr_s;
   logic                    sdata_s;
   logic                    bclk_d_reg;
   logic                    rise;
   logic                    rise_reg;
   logic                    lr_reg;
   logic                    sdata_reg;
   logic                    have_lr_reg;
   logic                    lr_prev_reg;
   logic                    armed_reg;
   logic                    left_valid_reg;
   logic [CNT_W-1:0]        bit_cnt_reg;
   logic [SAMPLE_WIDTH-1:0] shift_reg;
   logic [SAMPLE_WIDTH-1:0] left_hold_reg;
   logic [SAMPLE_WIDTH-1:0] line_in_l_reg;
   logic [SAMPLE_WIDTH-1:0] line_in_r_reg;
   logic [SAMPLE_WIDTH-1:0] word_next;
   logic                    new_sample_reg;
   logic                    frame_error_reg;

   assign bclk_s    = bclk_sync_reg[SYNC_STAGES-1];
   assign lr_s      = lr_sync_reg[SYNC_STAGES-1];
   assign sdata_s   = sdata_sync_reg[SYNC_STAGES-1];
   assign rise      = bclk_s & ~bclk_d_reg;
   assign word_next = {shift_reg[SAMPLE_WIDTH-2:0], sdata_reg};

   always_ff @(posedge clk) begin
      if (reset) begin
         bclk_sync_reg  <= '0;
         lr_sync_reg    <= '0;
         sdata_sync_reg <= '0;
         bclk_d_reg     <= 1'b0;
         rise_reg       <= 1'b0;
         lr_reg         <= 1'b0;
         sdata_reg      <= 1'b0;
      end else begin
         bclk_sync_reg  <= {bclk_sync_reg[SYNC_STAGES-2:0], bus.i2s_bclk};
         lr_sync_reg    <= {lr_sync_reg[SYNC_STAGES-2:0], bus.i2s_lr};
         sdata_sync_reg <= {sdata_sync_reg[SYNC_STAGES-2:0], bus.i2s_sdata};
         bclk_d_reg     <= bclk_s;
         // Edge strobe and its lr/data are pipelined together, so the
         // decode below always sees a coherent snapshot of one bclk rise.
         rise_reg       <= rise;
         lr_reg         <= lr_s;
         sdata_reg      <= sdata_s;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         have_lr_reg     <= 1'b0;
         lr_prev_reg     <= 1'b0;
         armed_reg       <= 1'b0;
         left_valid_reg  <= 1'b0;
         bit_cnt_reg     <= '0;
         shift_reg       <= '0;
         left_hold_reg   <= '0;
         line_in_l_reg   <= '0;
         line_in_r_reg   <= '0;
         new_sample_reg  <= 1'b0;
         frame_error_reg <= 1'b0;
      end else begin
         new_sample_reg  <= 1'b0;
         frame_error_reg <= 1'b0;
         if (rise_reg) begin
            if (!have_lr_reg) begin
               have_lr_reg <= 1'b1;
               lr_prev_reg <= lr_reg;
            end else if (lr_reg != lr_prev_reg) begin
               // One-bit-delay slot: its data belongs to the previous word.
               if (armed_reg && (bit_cnt_reg < FULL_CNT)) begin
                  frame_error_reg <= 1'b1;
                  if (!lr_prev_reg) begin
                     left_valid_reg <= 1'b0;
                  end
               end
               bit_cnt_reg <= '0;
               armed_reg   <= 1'b1;
               lr_prev_reg <= lr_reg;
            end else if (armed_reg && (bit_cnt_reg < FULL_CNT)) begin
               shift_reg   <= word_next;
               bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
               if (bit_cnt_reg == LAST_CNT) begin
                  if (!lr_prev_reg) begin
                     left_hold_reg  <= word_next;
                     left_valid_reg <= 1'b1;
                  end else if (left_valid_reg) begin
                     line_in_l_reg  <= left_hold_reg;
                     line_in_r_reg  <= word_next;
                     new_sample_reg <= 1'b1;
                     left_valid_reg <= 1'b0;
                  end
               end
            end
         end
      end
   end

   assign bus.line_in_l   = line_in_l_reg;
   assign bus.line_in_r   = line_in_r_reg;
   assign bus.new_sample  = new_sample_reg;
   assign bus.frame_error = frame_error_reg;
endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench for i2s_rx_deserializer: drives I2S frames from a vector table
// plus hand-written reset/start-up sequences and checks decoded pairs.
module tb_i2s_rx_deserializer;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   i2s_rx_deserializer_if #(.SAMPLE_WIDTH(24)) bus ();

   i2s_rx_deserializer #(.SAMPLE_WIDTH(24), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
      int          lbits;
      int          pad;
      int          half;
      int          exp_ns;
      int          exp_fe;
      logic [23:0] exp_l;
      logic [23:0] exp_r;
   } vec_t;

   vec_t vecs [9];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   ns_cnt = 0;
   int   fe_cnt = 0;
   int   mark   = 0;
   int   last_lat = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Pulse monitor, sampled 1 ns after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (bus.new_sample === 1'b1) begin
            ns_cnt++;
            last_lat = cyc - mark;
         end
         if (bus.frame_error === 1'b1) fe_cnt++;
         if (bus.new_sample === 1'b1 || bus.frame_error === 1'b1)
            check("pulse_exclusive", {31'b0, bus.new_sample & bus.frame_error}, 32'd0);
      end
   end

   // One bclk period starting and ending on a falling clk edge: h clk cycles low, h high.
   task automatic bit_period(input logic lr, input logic d, input int h,
                             input bit is_data, input bit do_rst);
      bus.i2s_bclk  = 1'b0;
      bus.i2s_lr    = lr;
      bus.i2s_sdata = d;
      if (do_rst) begin
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         check("rst_mid_l", {8'b0, bus.line_in_l}, 32'd0);
         check("rst_mid_r", {8'b0, bus.line_in_r}, 32'd0);
         repeat (h - 1) @(negedge clk);
      end else begin
         repeat (h) @(negedge clk);
      end
      bus.i2s_bclk = 1'b1;
      if (is_data) mark = cyc;
      repeat (h) @(negedge clk);
   endtask

   // Delay bit (sent as 1, must be discarded), MSB-first data, then 1-padding.
   task automatic send_slot(input logic lr, input logic [23:0] w, input int nbits,
                            input int npad, input int h, input int rst_bit);
      bit_period(lr, 1'b1, h, 1'b0, 1'b0);
      for (int i = 0; i < nbits; i++)
         bit_period(lr, w[23-i], h, 1'b1, (rst_bit == i + 1));
      for (int i = 0; i < npad; i++)
         bit_period(lr, 1'b1, h, 1'b0, 1'b0);
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int lbits,
                             input int pad, input int h, input int rst_bit);
      send_slot(1'b0, l, lbits, (lbits < 24) ? 0 : pad, h, -1);
      send_slot(1'b1, r, 24, pad, h, rst_bit);
      bus.i2s_bclk = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      int ns0;
      int fe0;
      vecs[0] = '{24'hABCDEF, 24'h123456, 24, 7, 16, 1, 0, 24'hABCDEF, 24'h123456};
      vecs[1] = '{24'hABCDEF, 24'h123456, 24, 7, 16, 1, 0, 24'hABCDEF, 24'h123456};
      vecs[2] = '{24'h800000, 24'h7FFFFF, 24, 7,  8, 1, 0, 24'h800000, 24'h7FFFFF};
      vecs[3] = '{24'h000000, 24'hFFFFFF, 24, 7,  8, 1, 0, 24'h000000, 24'hFFFFFF};
      vecs[4] = '{24'h111111, 24'h222222, 16, 7,  8, 0, 1, 24'h000000, 24'hFFFFFF};
      vecs[5] = '{24'h345678, 24'h9ABCDE, 24, 7, 16, 1, 0, 24'h345678, 24'h9ABCDE};
      vecs[6] = '{24'h5A5A5A, 24'hA5A5A5, 24, 0, 16, 1, 0, 24'h5A5A5A, 24'hA5A5A5};
      vecs[7] = '{24'hC3C3C3, 24'h3C3C3C, 24, 0,  2, 1, 0, 24'hC3C3C3, 24'h3C3C3C};
      vecs[8] = '{24'h0F0F0F, 24'hF0F0F0, 24, 7,  2, 1, 0, 24'h0F0F0F, 24'hF0F0F0};

      reset         = 1'b1;
      bus.i2s_bclk  = 1'b0;
      bus.i2s_lr    = 1'b1;
      bus.i2s_sdata = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_l", {8'b0, bus.line_in_l}, 32'd0);
      check("reset_r", {8'b0, bus.line_in_r}, 32'd0);
      check("reset_ns", {31'b0, bus.new_sample}, 32'd0);
      check("reset_fe", {31'b0, bus.frame_error}, 32'd0);
      reset = 1'b0;

      // Start mid right slot: the partial slot must produce nothing.
      ns0 = ns_cnt;
      fe0 = fe_cnt;
      for (int i = 0; i < 8; i++)
         bit_period(1'b1, i[0], 16, 1'b0, 1'b0);
      bus.i2s_bclk = 1'b0;
      repeat (12) @(negedge clk);
      check("rfirst_ns", ns_cnt - ns0, 32'd0);
      check("rfirst_fe", fe_cnt - fe0, 32'd0);
      $display("start-up partial right slot: ns=%0d fe=%0d", ns_cnt - ns0, fe_cnt - fe0);

      for (int v = 0; v < 9; v++) begin
         ns0 = ns_cnt;
         fe0 = fe_cnt;
         send_frame(vecs[v].l, vecs[v].r, vecs[v].lbits, vecs[v].pad, vecs[v].half, -1);
         check($sformatf("v%0d_ns", v), ns_cnt - ns0, vecs[v].exp_ns);
         check($sformatf("v%0d_fe", v), fe_cnt - fe0, vecs[v].exp_fe);
         check($sformatf("v%0d_l", v), {8'b0, bus.line_in_l}, {8'b0, vecs[v].exp_l});
         check($sformatf("v%0d_r", v), {8'b0, bus.line_in_r}, {8'b0, vecs[v].exp_r});
         if (vecs[v].exp_ns == 1)
            check($sformatf("v%0d_latency", v), last_lat, 32'd4);
         $display("frame %0d: l=%h r=%h ns=%0d fe=%0d lat=%0d", v, bus.line_in_l,
                  bus.line_in_r, ns_cnt - ns0, fe_cnt - fe0, last_lat);
      end

      // Reset for one cycle during the right slot, then a normal frame.
      ns0 = ns_cnt;
      fe0 = fe_cnt;
      send_frame(24'h13579B, 24'h2468AC, 24, 7, 8, 10);
      check("rstframe_ns", ns_cnt - ns0, 32'd0);
      check("rstframe_fe", fe_cnt - fe0, 32'd0);
      $display("reset frame: l=%h r=%h ns=%0d", bus.line_in_l, bus.line_in_r, ns_cnt - ns0);
      ns0 = ns_cnt;
      fe0 = fe_cnt;
      send_frame(24'hFEDCBA, 24'h0ABCDE, 24, 7, 8, -1);
      check("post_rst_ns", ns_cnt - ns0, 32'd1);
      check("post_rst_fe", fe_cnt - fe0, 32'd0);
      check("post_rst_l", {8'b0, bus.line_in_l}, 32'h00FEDCBA);
      check("post_rst_r", {8'b0, bus.line_in_r}, 32'h000ABCDE);
      $display("post-reset frame: l=%h r=%h ns=%0d", bus.line_in_l, bus.line_in_r,
               ns_cnt - ns0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
